// File: rtl/unsigned_mult_pkg.sv
// Shared constants for the sequential shift-add unsigned multiplier.
package unsigned_mult_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int CNT_W     = $clog2(DEF_WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/unsigned_multiplier_if.sv
// Start/ready handshake bundle between a requester (master) and the multiplier (slave).
interface unsigned_multiplier_if #(parameter int WIDTH = 32);

  logic                 start;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2*WIDTH-1:0]   product;
  logic                 ready;
  logic                 busy;

  modport master (output start, A, B, input product, ready, busy);
  modport slave  (input start, A, B, output product, ready, busy);

endinterface

// File: rtl/unsigned_mult_step.sv
// One add-and-shift iteration: conditionally add mcand into the high half, then shift right.
module unsigned_mult_step
  import unsigned_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2*WIDTH-1:0] product,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] product_nxt
);

  logic [WIDTH:0] sum;

  // The carry out of the high-half add lands in the MSB after the shift.
  always_comb begin
    sum         = {1'b0, product[2*WIDTH-1:WIDTH]} + (product[0] ? {1'b0, mcand} : '0);
    product_nxt = {sum, product[WIDTH-1:1]};
  end

endmodule

// File: rtl/unsigned_multiplier.sv
// Sequential unsigned multiplier retiring one multiplier bit per clock.
//   state | meaning
//   IDLE  | no result yet since reset
//   RUN   | iterating, product holds partial sums
//   DONE  | result held in product, ready high
module unsigned_multiplier
  import unsigned_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  unsigned_multiplier_if.slave bus
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] product_r;
  logic [2*WIDTH-1:0] product_nxt;
  logic               ready_r;
  logic               busy_r;

  unsigned_mult_step #(.WIDTH(WIDTH)) u_step (
    .product     (product_r),
    .mcand       (mcand),
    .product_nxt (product_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mcand     <= '0;
      product_r <= '0;
      ready_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            mcand     <= bus.A;
            product_r <= {{WIDTH{1'b0}}, bus.B};
            cnt       <= '0;
            ready_r   <= 1'b0;
            busy_r    <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          // start is deliberately ignored here, including on the completing edge.
          product_r <= product_nxt;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST) begin
            state   <= DONE;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.product = product_r;
  assign bus.ready   = ready_r;
  assign bus.busy    = busy_r;

endmodule

// File: tb/tb_unsigned_multiplier.sv
// Scoreboard bench for unsigned_multiplier: stimulus pushes expected products, monitor pops on ready.
module tb_unsigned_multiplier;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp;

  unsigned_multiplier_if #(.WIDTH(32)) bus ();

  unsigned_multiplier #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: on each rising ready, pop the oldest expected product and compare.
  initial begin
    logic prev_ready;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.ready && !prev_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %h expected none", bus.product);
        end else begin
          last_exp = exp_q.pop_front();
          chk("product", bus.product, last_exp);
          chk("busy_at_done", 64'(bus.busy), 64'd0);
        end
      end
      prev_ready = bus.ready;
    end
  end

  task automatic launch(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit push);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    bus.start = 1'b0;
    acc_cyc   = cyc;
    chk("busy_after_accept", 64'(bus.busy), 64'd1);
    chk("ready_after_accept", 64'(bus.ready), 64'd0);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!bus.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) chk({name, "_timeout"}, 64'(bus.ready), 64'd1);
    else chk({name, "_latency"}, 64'(cyc - acc_cyc), 64'd32);
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b,
                    input logic [63:0] exp, input string name);
    launch(a, b, exp, 1'b1);
    wait_ready(name);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    rst_n     = 1'b0;
    #12;
    chk("reset_product", bus.product, 64'd0);
    chk("reset_ready", 64'(bus.ready), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op(32'd3, 32'd5, 64'h0000_0000_0000_000F, "small");
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max");
    op(32'd0, 32'h1234_5678, 64'd0, "zero_a");
    op(32'h1234_5678, 32'd0, 64'd0, "zero_b");

    // Result stays held in DONE.
    repeat (5) @(negedge clk);
    chk("hold_ready", 64'(bus.ready), 64'd1);
    chk("hold_product", bus.product, 64'd0);

    // Start during RUN is ignored.
    launch(32'd7, 32'd9, 64'd63, 1'b1);
    repeat (9) @(negedge clk);
    bus.A     = 32'd2;
    bus.B     = 32'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_ready("ignore_start");
    repeat (3) @(negedge clk);
    chk("ignore_hold", bus.product, 64'd63);

    // Asynchronous reset mid-operation discards the result.
    launch(32'd100, 32'd200, 64'd0, 1'b0);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_product", bus.product, 64'd0);
    chk("abort_ready", 64'(bus.ready), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op(32'd100, 32'd200, 64'd20000, "after_reset");

    // Back-to-back: start held high across completion.
    @(negedge clk);
    bus.A     = 32'd1000;
    bus.B     = 32'd3000;
    bus.start = 1'b1;
    exp_q.push_back(64'd3000000);
    @(negedge clk);
    acc_cyc = cyc;
    bus.A   = 32'hDEAD_BEEF;
    bus.B   = 32'h0000_0010;
    exp_q.push_back(64'h0000_000D_EADB_EEF0);
    wait_ready("b2b_first");
    @(negedge clk);
    acc_cyc   = cyc;
    bus.start = 1'b0;
    chk("b2b_ready_drop", 64'(bus.ready), 64'd0);
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    wait_ready("b2b_second");

    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 10 == 0) rb = 32'hFFFF_FFFF;
      op(ra, rb, 64'(ra) * 64'(rb), "random");
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
